// File: rtl/spi_host_mc.sv
// Byte-wide SPI master: programmable SCK divider, NCS chip-selects, mode 0/3,
// auto-read bursts and a STATUS register with an overrun flag.
module spi_host_mc #(
    parameter int unsigned NCS       = 2,
    parameter int unsigned DIV_W     = 8,
    parameter int unsigned DIV_RESET = 1
) (
    input  logic           clk28,
    input  logic           rst,
    input  logic           cs,
    input  logic [1:0]     addr,
    input  logic           wr,
    input  logic           rd,
    input  logic [7:0]     din,
    output logic [7:0]     dout,
    output logic           dout_active,
    input  logic           sd_cd,
    input  logic           spi_miso,
    output logic           spi_mosi,
    output logic           spi_sck,
    output logic [NCS-1:0] spi_cs_n,
    output logic           busy,
    output logic           ext_wait
);

    typedef enum logic {S_IDLE, S_XFER} state_t;

    state_t           state_q, state_d;
    logic [NCS-1:0]   ctrl_cs_q, ctrl_cs_d;
    logic [NCS-1:0]   cs_n_q, cs_n_d;
    logic             cpol_q, cpol_d;
    logic             autord_q, autord_d;
    logic             mode_q, mode_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] div_lat_q, div_lat_d;
    logic [DIV_W-1:0] hc_q, hc_d;
    logic [3:0]       ph_q, ph_d;
    logic             sck_q, sck_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       rxsh_q, rxsh_d;
    logic [7:0]       rx_q, rx_d;
    logic             ovr_q, ovr_d;
    logic [7:0]       dout_q, dout_d;
    logic             dact_q, dact_d;

    logic             busy_w, wr_s, rd_s, data_wr, data_rd, start;
    logic [7:0]       ctrl_rd;

    always_comb begin
        state_d   = state_q;
        ctrl_cs_d = ctrl_cs_q;
        cs_n_d    = cs_n_q;
        cpol_d    = cpol_q;
        autord_d  = autord_q;
        mode_d    = mode_q;
        div_d     = div_q;
        div_lat_d = div_lat_q;
        hc_d      = hc_q;
        ph_d      = ph_q;
        sck_d     = sck_q;
        shift_d   = shift_q;
        rxsh_d    = rxsh_q;
        rx_d      = rx_q;
        ovr_d     = ovr_q;
        dout_d    = dout_q;
        dact_d    = 1'b0;

        busy_w  = (state_q == S_XFER);
        wr_s    = cs & wr;
        rd_s    = cs & rd;
        data_wr = wr_s && (addr == 2'd0);
        data_rd = rd_s && (addr == 2'd0);
        start   = !busy_w && (data_wr || (data_rd && autord_q));

        ctrl_rd          = '0;
        ctrl_rd[NCS-1:0] = ctrl_cs_q;
        ctrl_rd[6]       = cpol_q;
        ctrl_rd[7]       = autord_q;

        // CS pins are a separate register so they can reset high while CTRL resets to 0
        if (wr_s && addr == 2'd1) begin
            ctrl_cs_d = din[NCS-1:0];
            cs_n_d    = din[NCS-1:0];
            cpol_d    = din[6];
            autord_d  = din[7];
        end
        if (wr_s && addr == 2'd2)
            div_d = DIV_W'(din);

        if (rd_s && addr == 2'd3)
            ovr_d = 1'b0;
        if (data_wr && busy_w)
            ovr_d = 1'b1;

        if (rd_s) begin
            dact_d = 1'b1;
            case (addr)
                2'd0:    dout_d = rx_q;
                2'd1:    dout_d = ctrl_rd;
                2'd2:    dout_d = 8'(div_q);
                default: dout_d = {5'b0, ovr_q, sd_cd, busy_w};
            endcase
        end

        case (state_q)
            S_IDLE: begin
                sck_d = cpol_q;
                if (start) begin
                    state_d   = S_XFER;
                    shift_d   = data_wr ? din : 8'hFF;
                    hc_d      = '0;
                    ph_d      = '0;
                    div_lat_d = div_q;
                    mode_d    = cpol_q;
                end
            end
            default: begin
                if (hc_q == div_lat_q) begin
                    hc_d  = '0;
                    ph_d  = ph_q + 4'd1;
                    sck_d = ~sck_q;
                    // Mode 3 opens with a falling edge that must not shift
                    if (!sck_q)
                        rxsh_d = {rxsh_q[6:0], spi_miso};
                    else if (ph_q != 4'd0)
                        shift_d = {shift_q[6:0], 1'b1};
                    if (ph_q == 4'd15) begin
                        state_d = S_IDLE;
                        rx_d    = rxsh_d;
                    end
                end else begin
                    hc_d = hc_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk28) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ctrl_cs_q <= '0;
            cs_n_q    <= '1;
            cpol_q    <= 1'b0;
            autord_q  <= 1'b0;
            mode_q    <= 1'b0;
            div_q     <= DIV_W'(DIV_RESET);
            div_lat_q <= '0;
            hc_q      <= '0;
            ph_q      <= '0;
            sck_q     <= 1'b0;
            shift_q   <= '1;
            rxsh_q    <= '1;
            rx_q      <= 8'hFF;
            ovr_q     <= 1'b0;
            dout_q    <= '0;
            dact_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_cs_q <= ctrl_cs_d;
            cs_n_q    <= cs_n_d;
            cpol_q    <= cpol_d;
            autord_q  <= autord_d;
            mode_q    <= mode_d;
            div_q     <= div_d;
            div_lat_q <= div_lat_d;
            hc_q      <= hc_d;
            ph_q      <= ph_d;
            sck_q     <= sck_d;
            shift_q   <= shift_d;
            rxsh_q    <= rxsh_d;
            rx_q      <= rx_d;
            ovr_q     <= ovr_d;
            dout_q    <= dout_d;
            dact_q    <= dact_d;
        end
    end

    assign busy        = (state_q == S_XFER);
    assign ext_wait    = busy;
    assign spi_mosi    = busy ? shift_q[7] : 1'b1;
    assign spi_sck     = sck_q;
    assign spi_cs_n    = cs_n_q;
    assign dout        = dout_q;
    assign dout_active = dact_q;

endmodule

// File: tb/tb_spi_host_mc.sv
// Self-checking bench for spi_host_mc: directed scenarios plus randomized
// transfers compared against a byte-level reference model.
module tb_spi_host_mc;

    localparam int unsigned NCS = 2;

    logic           clk28 = 1'b0;
    logic           rst, cs, wr, rd, sd_cd;
    logic [1:0]     addr;
    logic [7:0]     din;
    logic [7:0]     dout;
    logic           dout_active, spi_miso, spi_mosi, spi_sck, busy, ext_wait;
    logic [NCS-1:0] spi_cs_n;

    int unsigned n_chk = 0;
    int unsigned n_fail = 0;

    logic [7:0] m_rx, m_ctrl, m_div;
    logic       m_ovr;
    logic       loop_en;
    logic [7:0] miso_pat, mosi_bits;
    int         rise_cnt, fall_cnt;
    logic       prev_sck, prev_mosi;

    always #5 clk28 = ~clk28;

    assign spi_miso = loop_en ? spi_mosi :
                      ((rise_cnt < 8) ? miso_pat[3'(7 - rise_cnt)] : 1'b1);

    spi_host_mc #(.NCS(NCS), .DIV_W(8), .DIV_RESET(1)) dut (
        .clk28(clk28), .rst(rst), .cs(cs), .addr(addr), .wr(wr), .rd(rd),
        .din(din), .dout(dout), .dout_active(dout_active), .sd_cd(sd_cd),
        .spi_miso(spi_miso), .spi_mosi(spi_mosi), .spi_sck(spi_sck),
        .spi_cs_n(spi_cs_n), .busy(busy), .ext_wait(ext_wait)
    );

    task automatic tick;
        @(posedge clk28);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_in;
        cs = 1'b0; wr = 1'b0; rd = 1'b0; addr = 2'd0; din = 8'h00;
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
        cs = 1'b1; wr = 1'b1; addr = a; din = d;
        tick();
        idle_in();
    endtask

    task automatic rd_chk(input logic [1:0] a, input logic [7:0] exp, input string tag);
        cs = 1'b1; rd = 1'b1; addr = a;
        tick();
        idle_in();
        chk(tag, dout, exp);
        chk({tag, "_act"}, dout_active, 1);
    endtask

    task automatic set_ctrl(input logic [7:0] d);
        wr_reg(2'd1, d);
        m_ctrl = d;
    endtask

    task automatic set_div(input logic [7:0] d);
        wr_reg(2'd2, d);
        m_div = d;
    endtask

    task automatic observe;
        if (!prev_sck && spi_sck) begin
            rise_cnt++;
            mosi_bits = {mosi_bits[6:0], prev_mosi};
        end
        if (prev_sck && !spi_sck) fall_cnt++;
        prev_sck  = spi_sck;
        prev_mosi = spi_mosi;
    endtask

    // inj: 0 none, 1 overrun write + two STATUS reads, 2 DATA read on the completion cycle
    task automatic xfer(input bit use_rd, input logic [7:0] tx, input logic [7:0] pat,
                        input bit lb, input int inj, input string tag);
        logic [7:0] exp_tx, exp_rx, old_rx;
        logic       cpol, ovr;
        int         n, k, nexp;
        tick();
        cpol   = m_ctrl[6];
        exp_tx = use_rd ? 8'hFF : tx;
        exp_rx = lb ? exp_tx : pat;
        nexp   = 16 * (int'(m_div) + 1);
        old_rx = m_rx;
        ovr    = m_ovr;
        loop_en = lb; miso_pat = pat; rise_cnt = 0; fall_cnt = 0; mosi_bits = '0;
        chk({tag, "_sck_idle_pre"}, spi_sck, cpol);
        prev_sck = spi_sck; prev_mosi = spi_mosi;
        if (use_rd) rd_chk(2'd0, old_rx, {tag, "_autord_old_rx"});
        else        wr_reg(2'd0, tx);
        n = 0;
        while (busy === 1'b1 && n < 2000) begin
            observe();
            k = n;
            if (inj == 1 && k == 1) begin cs = 1; wr = 1; addr = 2'd0; din = 8'h22; ovr = 1'b1; end
            if (inj == 1 && (k == 3 || k == 5)) begin cs = 1; rd = 1; addr = 2'd3; end
            if (inj == 2 && k == nexp - 1) begin cs = 1; rd = 1; addr = 2'd0; end
            n++;
            tick();
            idle_in();
            if (inj == 1 && (k == 3 || k == 5)) begin
                chk({tag, "_status_busy"}, dout, {5'b0, ovr, 1'b0, 1'b1});
                ovr = 1'b0;
            end
            if (inj == 2 && k == nexp - 1)
                chk({tag, "_rd_at_completion"}, dout, old_rx);
        end
        observe();
        chk({tag, "_busy_cycles"}, n, nexp);
        chk({tag, "_rising_edges"}, rise_cnt, 8);
        chk({tag, "_falling_edges"}, fall_cnt, 8);
        chk({tag, "_mosi_bits"}, mosi_bits, exp_tx);
        chk({tag, "_sck_idle_post"}, spi_sck, cpol);
        chk({tag, "_mosi_idle"}, spi_mosi, 1'b1);
        m_rx  = exp_rx;
        m_ovr = ovr;
        if (inj == 2) begin
            tick();
            chk({tag, "_no_restart"}, busy, 1'b0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] tx, pat, ctrl;
        logic [1:0] dv;
        bit         ur;
        idle_in();
        rst = 1'b1; sd_cd = 1'b0; loop_en = 1'b0; miso_pat = 8'hFF; rise_cnt = 8;
        m_rx = 8'hFF; m_ctrl = 8'h00; m_div = 8'd1; m_ovr = 1'b0;
        tick(); tick(); tick();
        rst = 1'b0;

        // reset state
        chk("rst_busy", busy, 1'b0);
        chk("rst_wait", ext_wait, 1'b0);
        chk("rst_sck", spi_sck, 1'b0);
        chk("rst_mosi", spi_mosi, 1'b1);
        chk("rst_cs_n", spi_cs_n, 2'b11);
        chk("rst_dout", dout, 8'h00);
        chk("rst_dact", dout_active, 1'b0);
        rd_chk(2'd3, 8'h00, "status_rst");
        tick();
        chk("dact_one_cycle", dout_active, 1'b0);
        sd_cd = 1'b1;
        rd_chk(2'd3, 8'h02, "status_sdcd");
        sd_cd = 1'b0;
        rd_chk(2'd1, 8'h00, "ctrl_rst");
        rd_chk(2'd2, 8'h01, "div_rst");
        rd_chk(2'd0, 8'hFF, "rx_rst");

        // mode 0, fastest divider, loopback
        set_div(8'd0);
        set_ctrl(8'h02);
        chk("cs0_low", spi_cs_n, 2'b10);
        xfer(1'b0, 8'hA5, 8'h00, 1'b1, 0, "lb_a5");
        rd_chk(2'd0, 8'hA5, "lb_rx");

        // mode 3, DIV=3, MISO tied low
        set_div(8'd3);
        set_ctrl(8'h42);
        rd_chk(2'd1, 8'h42, "ctrl_rb");
        xfer(1'b0, 8'h96, 8'h00, 1'b0, 0, "m3");
        rd_chk(2'd0, 8'h00, "m3_rx");

        // overrun while busy
        set_div(8'd1);
        set_ctrl(8'h02);
        xfer(1'b0, 8'h11, 8'h5E, 1'b0, 1, "ovr");
        rd_chk(2'd3, 8'h00, "status_after_ovr");

        // auto-read bursts
        set_ctrl(8'h82);
        xfer(1'b1, 8'h00, 8'h3C, 1'b0, 0, "ar1");
        xfer(1'b1, 8'h00, 8'hC3, 1'b0, 2, "ar2");
        set_ctrl(8'h02);
        rd_chk(2'd0, 8'hC3, "ar2_rx");

        // randomized transfers
        for (int i = 0; i < 8; i++) begin
            dv   = 2'($urandom_range(0, 3));
            ur   = 1'($urandom_range(0, 1));
            ctrl = {ur, 1'($urandom_range(0, 1)), 4'b0, 2'($urandom_range(0, 3))};
            tx   = 8'($urandom);
            pat  = 8'($urandom);
            set_div({6'b0, dv});
            set_ctrl(ctrl);
            rd_chk(2'd1, m_ctrl & 8'hC3, "rnd_ctrl_rb");
            chk("rnd_cs_n", spi_cs_n, ctrl[1:0]);
            xfer(ur, tx, pat, 1'b0, 0, "rnd");
        end
        set_ctrl(8'h00);
        rd_chk(2'd0, m_rx, "rnd_rx");

        // reset mid-transfer
        set_div(8'd1);
        set_ctrl(8'h02);
        tick();
        wr_reg(2'd0, 8'h5A);
        for (int i = 0; i < 14; i++) tick();
        chk("mid_busy", busy, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_sck", spi_sck, 1'b0);
        chk("abort_cs_n", spi_cs_n, 2'b11);
        chk("abort_mosi", spi_mosi, 1'b1);
        rd_chk(2'd0, 8'hFF, "abort_rx");
        rd_chk(2'd1, 8'h00, "abort_ctrl");
        rd_chk(2'd2, 8'h01, "abort_div");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
